// File: rtl/program_counter_pkg.sv
// Shared CPU constants and the priority-resolved PC command set.
// The PC_FAULT_EN macro is consumed by program_counter.sv, not here.
package program_counter_pkg;

   localparam int                     PC_WIDTH     = 16;
   localparam logic [PC_WIDTH-1:0]    PC_RESET_VEC = '0;
   localparam logic [PC_WIDTH-1:0]    PC_TRAP_VEC  = '1;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_LOAD,
      PC_CALL,
      PC_RET,
      PC_RST
   } pc_cmd_e;

   // rst_n low > ret > call > load > inc > hold
   function automatic pc_cmd_e pc_resolve(input logic rst_n, input logic ret,
                                          input logic call, input logic load,
                                          input logic inc);
      if (!rst_n)    return PC_RST;
      else if (ret)  return PC_RET;
      else if (call) return PC_CALL;
      else if (load) return PC_LOAD;
      else if (inc)  return PC_INC;
      else           return PC_HOLD;
   endfunction

endpackage

// File: rtl/program_counter_if.sv
// Control-unit to program-counter bus: commands and target in, pc and stack status out.
interface program_counter_if
   import program_counter_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH
);
   logic             load;
   logic             inc;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] addr;
   logic [WIDTH-1:0] pc;
   logic             stack_empty;
   logic             stack_full;
   logic             fault;

   modport master (
      output load, inc, call, ret, addr,
      input  pc, stack_empty, stack_full, fault
   );

   modport slave (
      input  load, inc, call, ret, addr,
      output pc, stack_empty, stack_full, fault
   );
endinterface

// File: rtl/program_counter_return_stack.sv
// return_stack: LIFO of DEPTH words, registered empty/full flags.
// With wrap set, a push while full overwrites the oldest entry.
module return_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             wrap,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr, ptr_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic             do_push, do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && !do_pop && (!full || wrap);

   // ptr is the next free slot; when full it also indexes the oldest entry
   always_comb begin
      ptr_next = ptr;
      cnt_next = cnt;
      if (do_pop) begin
         ptr_next = ptr - PW'(1);
         cnt_next = cnt - CW'(1);
      end else if (do_push) begin
         ptr_next = ptr + PW'(1);
         if (!full) cnt_next = cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr   <= '0;
         cnt   <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         ptr   <= ptr_next;
         cnt   <= cnt_next;
         empty <= (cnt_next == '0);
         full  <= (cnt_next == CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[ptr] <= wdata;
   end

   assign rdata = mem[ptr - PW'(1)];

endmodule

// File: rtl/program_counter.sv
// Program counter with return-address stack: hold/inc/load/call/ret.
// Define PC_FAULT_EN to trap to TRAP_VEC with a sticky fault on stack over/underflow.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int               WIDTH     = PC_WIDTH,
   parameter int               DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
   parameter logic [WIDTH-1:0] TRAP_VEC  = '1
) (
   input  logic               clk,
   input  logic               rst_n,
   program_counter_if.slave   bus
);
`ifdef PC_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   pc_cmd_e          cmd;
   logic [WIDTH-1:0] pc_q, pc_next, pc_plus1, top_word;
   logic             push, pop, empty, full;

   assign cmd      = pc_resolve(rst_n, bus.ret, bus.call, bus.load, bus.inc);
   assign pc_plus1 = pc_q + WIDTH'(1);
   assign push     = (cmd == PC_CALL) && !(full && FAULT_EN);
   assign pop      = (cmd == PC_RET) && !empty;

   always_comb begin
      pc_next = pc_q;
      case (cmd)
         PC_RST:  pc_next = RESET_VEC;
         PC_RET: begin
            if (!empty)        pc_next = top_word;
            else if (FAULT_EN) pc_next = TRAP_VEC;
         end
         PC_CALL: pc_next = (full && FAULT_EN) ? TRAP_VEC : bus.addr;
         PC_LOAD: pc_next = bus.addr;
         PC_INC:  pc_next = pc_plus1;
         default: pc_next = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pc_q <= RESET_VEC;
      else        pc_q <= pc_next;
   end

   return_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wrap  (~FAULT_EN),
      .wdata (pc_plus1),
      .rdata (top_word),
      .empty (empty),
      .full  (full)
   );

`ifdef PC_FAULT_EN
   logic fault_q;
   always_ff @(posedge clk) begin
      if (!rst_n)
         fault_q <= 1'b0;
      else if ((cmd == PC_RET && empty) || (cmd == PC_CALL && full))
         fault_q <= 1'b1;
   end
   assign bus.fault = fault_q;
`else
   assign bus.fault = 1'b0;
`endif

   assign bus.pc          = pc_q;
   assign bus.stack_empty = empty;
   assign bus.stack_full  = full;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: queue-based reference model checked every cycle plus directed literals.
module tb_program_counter;
   localparam int          W     = 16;
   localparam int          DEPTH = 8;
   localparam logic [15:0] RVEC  = 16'h0000;
   localparam logic [15:0] TVEC  = 16'hFFFF;
`ifdef PC_FAULT_EN
   localparam bit FE = 1'b1;
`else
   localparam bit FE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   program_counter_if #(.WIDTH(W)) bus ();

   program_counter #(
      .WIDTH     (W),
      .DEPTH     (DEPTH),
      .RESET_VEC (RVEC),
      .TRAP_VEC  (TVEC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // reference model: a queue holding return addresses, oldest at the front
   logic [15:0] m_pc;
   logic [15:0] m_stk[$];
   logic        m_fault;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_pc    = RVEC;
         m_stk   = {};
         m_fault = 1'b0;
         chk_en  = 1'b1;
      end else if (bus.ret) begin
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else if (FE) begin
            m_fault = 1'b1;
            m_pc    = TVEC;
         end
      end else if (bus.call) begin
         if (m_stk.size() < DEPTH) begin
            m_stk.push_back(m_pc + 16'd1);
            m_pc = bus.addr;
         end else if (FE) begin
            m_fault = 1'b1;
            m_pc    = TVEC;
         end else begin
            void'(m_stk.pop_front());
            m_stk.push_back(m_pc + 16'd1);
            m_pc = bus.addr;
         end
      end else if (bus.load) m_pc = bus.addr;
      else if (bus.inc)      m_pc = m_pc + 16'd1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_pc",    32'(bus.pc),          32'(m_pc));
         check("model_empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
         check("model_full",  32'(bus.stack_full),  32'(m_stk.size() == DEPTH));
         check("model_fault", 32'(bus.fault),       32'(m_fault));
      end
   end

   task automatic step(input logic ld, input logic ic, input logic ca, input logic re,
                       input logic [15:0] ad);
      bus.load = ld;
      bus.inc  = ic;
      bus.call = ca;
      bus.ret  = re;
      bus.addr = ad;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(0, 0, 0, 0, 16'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      bus.load = 1'b0;
      bus.inc  = 1'b0;
      bus.call = 1'b0;
      bus.ret  = 1'b0;
      bus.addr = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_pc",    32'(bus.pc),          32'h0);
      check("rst_empty", 32'(bus.stack_empty), 32'h1);
      check("rst_full",  32'(bus.stack_full),  32'h0);
      check("rst_fault", 32'(bus.fault),       32'h0);

      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 0, 0, 16'h0);
         check("inc_pc", 32'(bus.pc), 32'(i));
      end
      check("inc_empty", 32'(bus.stack_empty), 32'h1);

      step(1, 0, 0, 0, 16'hFFFF);
      step(0, 1, 0, 0, 16'h0);
      check("inc_wrap", 32'(bus.pc), 32'h0);
      step(1, 0, 0, 0, 16'hFFFF);
      step(0, 0, 1, 0, 16'h0100);
      check("call_at_max", 32'(bus.pc), 32'h0100);
      step(0, 0, 0, 1, 16'h0);
      check("ret_wrapped", 32'(bus.pc), 32'h0);

      step(1, 0, 0, 0, 16'h0005);
      step(0, 0, 1, 0, 16'h0010);
      check("nest_call1", 32'(bus.pc), 32'h0010);
      step(0, 0, 1, 0, 16'h0020);
      check("nest_call2", 32'(bus.pc), 32'h0020);
      step(0, 0, 0, 1, 16'h0);
      check("nest_ret1", 32'(bus.pc), 32'h0011);
      step(0, 0, 0, 1, 16'h0);
      check("nest_ret2", 32'(bus.pc), 32'h0006);
      check("nest_empty", 32'(bus.stack_empty), 32'h1);

      step(1, 0, 0, 0, 16'h0041);
      step(0, 0, 1, 0, 16'h0200);
      step(1, 1, 1, 1, 16'h0300);
      check("prio_pc",    32'(bus.pc),          32'h0042);
      check("prio_empty", 32'(bus.stack_empty), 32'h1);

      do_reset();
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 16'h1000 + 16'(i));
      check("fill_full", 32'(bus.stack_full), 32'h1);
      step(0, 0, 1, 0, 16'h2000);
      if (FE) begin
         check("ovf_pc",    32'(bus.pc),         32'hFFFF);
         check("ovf_fault", 32'(bus.fault),      32'h1);
         check("ovf_full",  32'(bus.stack_full), 32'h1);
      end else begin
         check("ovf_pc",    32'(bus.pc),         32'h2000);
         check("ovf_fault", 32'(bus.fault),      32'h0);
         check("ovf_full",  32'(bus.stack_full), 32'h1);
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 0, 1, 16'h0);
         if (FE) check("drain_pc", 32'(bus.pc), (i < DEPTH - 1) ? 32'(16'h1007 - 16'(i)) : 32'h1);
         else    check("drain_pc", 32'(bus.pc), 32'(16'h1008 - 16'(i)));
      end
      check("drain_empty", 32'(bus.stack_empty), 32'h1);
      step(0, 0, 0, 1, 16'h0);
      check("unf_pc", 32'(bus.pc), FE ? 32'hFFFF : 32'h1001);
      check("unf_fault", 32'(bus.fault), FE ? 32'h1 : 32'h0);

      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 16'h0300 + 16'(i));
      rst_n = 1'b0;
      step(0, 0, 1, 0, 16'h0400);
      rst_n = 1'b1;
      check("mid_rst_pc",    32'(bus.pc),          32'(RVEC));
      check("mid_rst_empty", 32'(bus.stack_empty), 32'h1);
      check("mid_rst_fault", 32'(bus.fault),       32'h0);
      step(0, 0, 0, 1, 16'h0);
      check("post_rst_ret", 32'(bus.pc), FE ? 32'hFFFF : 32'(RVEC));

      step(0, 0, 0, 0, 16'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/program_counter.md
# program_counter

Parametrised program counter with an integrated return-address stack for the CPU datapath. It holds the address of the next instruction and supports hold, increment, absolute load, subroutine call and subroutine return. It sits between the instruction-fetch path (drives `pc` to instruction memory) and the control unit (drives `load`, `inc`, `call`, `ret`).

## Interface
- `WIDTH`, 16: address width in bits; ≥ 2.
- `DEPTH`, 8: return-stack entries; power of 2, ≥ 2.
- `RESET_VEC`, 0: `pc` value after reset.
- `TRAP_VEC`, all ones: `pc` value on stack fault; used only with `PC_FAULT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load`  in  1  jump: `pc <= addr`.
- `inc`  in  1  step: `pc <= pc + 1`.
- `call`  in  1  push `pc + 1`, then `pc <= addr`.
- `ret`  in  1  pop the top entry into `pc`.
- `addr`  in  WIDTH  target for `load`/`call`.
- `pc`  out  WIDTH  current program counter (registered).
- `stack_empty`  out  1  no entries held (registered).
- `stack_full`  out  1  DEPTH entries held (registered).
- `fault`  out  1  sticky stack over/underflow flag.

## Operation
- Per-cycle command priority: `rst_n` low > `ret` > `call` > `load` > `inc` > hold. Lower-priority requests in the same cycle are ignored with no side effect.
- Increment arithmetic: `pc + 1` is modulo 2^WIDTH. All ones wraps to 0, on both `inc` and the pushed return address.
- Stack: LIFO of DEPTH words with a pointer and a count from 0 to DEPTH.
  - Push writes `pc + 1` at the top.
  - Pop returns the most recent push.
- `call` when not full: push, set `pc <= addr`, increment count.
- `ret` when not empty: `pc <= top`, decrement count.
- `ret` when empty (underflow) and `call` when full (overflow): behaviour is set by the Configuration section.
- Reset values:
  - `pc = RESET_VEC`
  - count = 0, `stack_empty = 1`, `stack_full = 0`
  - `fault = 0`
  - stack contents don't-care.

## Timing
- Every output is a flop; there is no combinational path from input to output.
- A command sampled at edge N is visible on `pc` and the flags after edge N (1-cycle latency).
- Back-to-back `call`/`ret` on consecutive cycles is fully supported, with no bubbles.
- `ret` in the cycle right after `call` returns the just-pushed `pc + 1`.
- Reset in the middle of a call sequence discards all stack entries on that edge. Commands asserted in the same cycle as reset are ignored.
- `call` and `ret` asserted together: `ret` executes and `call` is dropped (no push).
- Flags follow the count on the same edge:
  - `stack_full` = (count == DEPTH)
  - `stack_empty` = (count == 0)

## Configuration
- Macro: `PC_FAULT_EN`.
- Defined:
  - Overflow sets `fault`, `pc <= TRAP_VEC`, and leaves the stack unchanged.
  - Underflow sets `fault` and `pc <= TRAP_VEC`.
  - `fault` stays high until reset.
- Undefined:
  - `fault` is tied to 0.
  - Overflow overwrites the oldest entry (circular): pointer advances, count stays DEPTH, `pc <= addr`.
  - Underflow is ignored; `pc` holds.

## Structure
- Shared CPU package holds:
  - default address width `PC_WIDTH = 16`
  - reset and trap vector constants
  - a command enumeration for the priority-resolved operation: `PC_HOLD`, `PC_INC`, `PC_LOAD`, `PC_CALL`, `PC_RET`, `PC_RST`.
- One sub-module, `return_stack`:
  - parameters WIDTH and DEPTH
  - ports: push, pop, wdata, rdata, empty, full, plus an overwrite-on-full mode input.
  - The top level does command priority, the incrementer and the `pc` register.

## Test plan
- Reset, then `inc` for 3 cycles → `pc` reads 0, 1, 2, 3; `stack_empty = 1`.
- `pc = 16'hFFFF`, then `inc` → `pc = 0`. `call` at `pc = 16'hFFFF` with `addr = 16'h0100` → `pc = 16'h0100`; then `ret` → `pc = 0`.
- Nested calls: `call` 16'h0010 from `pc` 5, then `call` 16'h0020 → `pc` goes 16'h0010, then 16'h0020. Then `ret`, `ret` → `pc` goes 16'h0011, then 6; `stack_empty = 1`.
- `call` + `ret` + `load` + `inc` all asserted with stack holding 16'h0042 → `pc = 16'h0042`, count decremented, no push.
- Fill 8 entries, then 9th `call`:
  - With `PC_FAULT_EN`: `pc = 16'hFFFF`, `fault = 1`, `stack_full = 1`.
  - Without: `pc = addr`, the first 8 `ret`s return the 8 most recent return addresses (newest first), `stack_empty = 1`, and a 9th `ret` holds `pc`.
- Reset asserted with 3 entries pending and `call` high → `pc = RESET_VEC`, `stack_empty = 1`, `fault = 0`.
